// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer for the pipelined RV32I core.
// Owns the PC and drives the program memory address. It captures the returned
// word into the IF/ID register and tracks whether each entry is a real
// instruction or a bubble. It also handles stalls, redirects and fetch faults.
// A fault is terminal until the next reset.
module fetch_controller #(
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC     = 32'h0040_0000,
  parameter int unsigned           MEMORY_DEPTH = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR    = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall_i,
  input  logic                  redirect_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  input  logic [DATA_WIDTH-1:0] imem_instr_i,
  output logic [DATA_WIDTH-1:0] if_pc_o,
  output logic [DATA_WIDTH-1:0] if_pc4_o,
  output logic [DATA_WIDTH-1:0] if_instr_o,
  output logic                  if_valid_o,
  output logic                  fault_o,
  output logic [1:0]            fault_code_o
);

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  localparam logic [1:0] CODE_NONE     = 2'b00;
  localparam logic [1:0] CODE_MISALIGN = 2'b01;
  localparam logic [1:0] CODE_RANGE    = 2'b10;

  localparam logic [DATA_WIDTH-1:0] PC_STEP     = DATA_WIDTH'(4);
  localparam logic [DATA_WIDTH-1:0] ZERO_WORD   = {DATA_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] DEPTH_WORDS = DATA_WIDTH'(MEMORY_DEPTH);

  // True when the word index of pc lies inside the program memory.
  // Addresses that wrapped past zero land below RESET_PC and fail here.
  function automatic logic pc_in_range(input logic [DATA_WIDTH-1:0] pc);
    logic [DATA_WIDTH-1:0] offset;
    logic [DATA_WIDTH-1:0] word_idx;
    logic                  ok;
    offset   = pc - RESET_PC;
    word_idx = {2'b00, offset[DATA_WIDTH-1:2]};
    if (pc < RESET_PC) begin
      ok = 1'b0;
    end else if (word_idx >= DEPTH_WORDS) begin
      ok = 1'b0;
    end else begin
      ok = 1'b1;
    end
    return ok;
  endfunction

  // True for a 4-byte-aligned byte address.
  function automatic logic is_word_aligned(input logic [DATA_WIDTH-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

  state_t                state_r,      state_s;
  logic [DATA_WIDTH-1:0] pc_r,         pc_s;
  logic [DATA_WIDTH-1:0] if_pc_r,      if_pc_s;
  logic [DATA_WIDTH-1:0] if_pc4_r,     if_pc4_s;
  logic [DATA_WIDTH-1:0] if_instr_r,   if_instr_s;
  logic                  if_valid_r,   if_valid_s;
  logic                  fault_r,      fault_s;
  logic [1:0]            fault_code_r, fault_code_s;

  // Next-state and next-register computation; every value holds by default.
  always_comb begin
    state_s      = state_r;
    pc_s         = pc_r;
    if_pc_s      = if_pc_r;
    if_pc4_s     = if_pc4_r;
    if_instr_s   = if_instr_r;
    if_valid_s   = if_valid_r;
    fault_s      = fault_r;
    fault_code_s = fault_code_r;

    case (state_r)
      ST_START: begin
        // One settling cycle: the bubble stays and stall/redirect are ignored.
        state_s    = ST_RUN;
        if_instr_s = NOP_INSTR;
        if_valid_s = 1'b0;
      end

      ST_RUN: begin
        if (redirect_i) begin
          if (!is_word_aligned(redirect_pc_i)) begin
            // A misaligned target is fatal; the PC stays on the last good fetch.
            state_s      = ST_HALT;
            fault_s      = 1'b1;
            fault_code_s = CODE_MISALIGN;
            if_instr_s   = NOP_INSTR;
            if_valid_s   = 1'b0;
          end else begin
            // Drop the wrong-path fetch and restart at the target.
            pc_s       = redirect_pc_i;
            if_instr_s = NOP_INSTR;
            if_valid_s = 1'b0;
          end
        end else if (stall_i) begin
          pc_s       = pc_r;
          if_pc_s    = if_pc_r;
          if_pc4_s   = if_pc4_r;
          if_instr_s = if_instr_r;
          if_valid_s = if_valid_r;
        end else if (!pc_in_range(pc_r)) begin
          // Memory data at a bad PC is never latched.
          state_s      = ST_HALT;
          fault_s      = 1'b1;
          fault_code_s = CODE_RANGE;
          if_instr_s   = NOP_INSTR;
          if_valid_s   = 1'b0;
        end else begin
          if_pc_s    = pc_r;
          if_pc4_s   = pc_r + PC_STEP;
          if_instr_s = imem_instr_i;
          if_valid_s = 1'b1;
          pc_s       = pc_r + PC_STEP;
        end
      end

      ST_HALT: begin
        // Terminal state: only reset leaves it.
        state_s    = ST_HALT;
        if_instr_s = NOP_INSTR;
        if_valid_s = 1'b0;
        fault_s    = 1'b1;
      end

      default: begin
        // An illegal encoding is treated as a fault so fetch can never resume silently.
        state_s      = ST_HALT;
        fault_s      = 1'b1;
        fault_code_s = CODE_RANGE;
        if_instr_s   = NOP_INSTR;
        if_valid_s   = 1'b0;
      end
    endcase
  end

  // State and IF/ID register update; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_START;
      pc_r         <= RESET_PC;
      if_pc_r      <= ZERO_WORD;
      if_pc4_r     <= ZERO_WORD;
      if_instr_r   <= NOP_INSTR;
      if_valid_r   <= 1'b0;
      fault_r      <= 1'b0;
      fault_code_r <= CODE_NONE;
    end else begin
      state_r      <= state_s;
      pc_r         <= pc_s;
      if_pc_r      <= if_pc_s;
      if_pc4_r     <= if_pc4_s;
      if_instr_r   <= if_instr_s;
      if_valid_r   <= if_valid_s;
      fault_r      <= fault_s;
      fault_code_r <= fault_code_s;
    end
  end

  assign imem_addr_o  = pc_r;
  assign if_pc_o      = if_pc_r;
  assign if_pc4_o     = if_pc4_r;
  assign if_instr_o   = if_instr_r;
  assign if_valid_o   = if_valid_r;
  assign fault_o      = fault_r;
  assign fault_code_o = fault_code_r;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller. The program memory model returns
// 32'h1000_0000 + word index (address[16:2]).
module tb_fetch_controller;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic [31:0] if_instr;
  logic        if_valid;
  logic        fault;
  logic [1:0]  fault_code;

  int vectors;
  int miscompares;

  fetch_controller dut (
    .clk           (clk),
    .reset         (reset),
    .stall_i       (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .imem_addr_o   (imem_addr),
    .imem_instr_i  (imem_instr),
    .if_pc_o       (if_pc),
    .if_pc4_o      (if_pc4),
    .if_instr_o    (if_instr),
    .if_valid_o    (if_valid),
    .fault_o       (fault),
    .fault_code_o  (fault_code)
  );

  assign imem_instr = 32'h1000_0000 + {17'd0, imem_addr[16:2]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;

    // Reset state
    step(); step();
    check("rst_addr",  imem_addr, 32'h0040_0000);
    check("rst_pc",    if_pc, 32'h0);
    check("rst_pc4",   if_pc4, 32'h0);
    check("rst_instr", if_instr, 32'h0000_0013);
    check("rst_valid", {31'd0, if_valid}, 32'h0);
    check("rst_fault", {31'd0, fault}, 32'h0);
    check("rst_code",  {30'd0, fault_code}, 32'h0);

    // START ignores redirect and stall
    reset = 1'b0; redirect = 1'b1; redirect_pc = 32'h0040_0040; stall = 1'b1;
    step();
    check("start_valid", {31'd0, if_valid}, 32'h0);
    check("start_addr",  imem_addr, 32'h0040_0000);
    check("start_instr", if_instr, 32'h0000_0013);

    // Free run
    redirect = 1'b0; stall = 1'b0;
    step();
    check("run0_pc",    if_pc, 32'h0040_0000);
    check("run0_pc4",   if_pc4, 32'h0040_0004);
    check("run0_instr", if_instr, 32'h1000_0000);
    check("run0_valid", {31'd0, if_valid}, 32'h1);
    check("run0_addr",  imem_addr, 32'h0040_0004);
    step();
    check("run1_pc",    if_pc, 32'h0040_0004);
    check("run1_instr", if_instr, 32'h1000_0001);
    step();
    check("run2_pc",    if_pc, 32'h0040_0008);
    check("run2_pc4",   if_pc4, 32'h0040_000C);
    check("run2_instr", if_instr, 32'h1000_0002);
    check("run2_addr",  imem_addr, 32'h0040_000C);

    // Stall for three cycles
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc",    if_pc, 32'h0040_0008);
      check("stall_pc4",   if_pc4, 32'h0040_000C);
      check("stall_instr", if_instr, 32'h1000_0002);
      check("stall_valid", {31'd0, if_valid}, 32'h1);
      check("stall_addr",  imem_addr, 32'h0040_000C);
    end
    stall = 1'b0;
    step();
    check("unstall_pc",    if_pc, 32'h0040_000C);
    check("unstall_instr", if_instr, 32'h1000_0003);
    check("unstall_addr",  imem_addr, 32'h0040_0010);

    // Redirect overrides stall
    redirect = 1'b1; redirect_pc = 32'h0040_0040; stall = 1'b1;
    step();
    check("redir_valid", {31'd0, if_valid}, 32'h0);
    check("redir_instr", if_instr, 32'h0000_0013);
    check("redir_addr",  imem_addr, 32'h0040_0040);
    check("redir_pc",    if_pc, 32'h0040_000C);
    redirect = 1'b0; stall = 1'b0;
    step();
    check("tgt_pc",    if_pc, 32'h0040_0040);
    check("tgt_pc4",   if_pc4, 32'h0040_0044);
    check("tgt_instr", if_instr, 32'h1000_0010);
    check("tgt_valid", {31'd0, if_valid}, 32'h1);
    check("tgt_addr",  imem_addr, 32'h0040_0044);

    // Last word in range, then fall off the end
    redirect = 1'b1; redirect_pc = 32'h0040_007C;
    step();
    check("end_bubble", {31'd0, if_valid}, 32'h0);
    check("end_addr",   imem_addr, 32'h0040_007C);
    redirect = 1'b0;
    step();
    check("last_pc",    if_pc, 32'h0040_007C);
    check("last_instr", if_instr, 32'h1000_001F);
    check("last_valid", {31'd0, if_valid}, 32'h1);
    check("last_fault", {31'd0, fault}, 32'h0);
    check("last_addr",  imem_addr, 32'h0040_0080);
    step();
    check("oor_fault", {31'd0, fault}, 32'h1);
    check("oor_code",  {30'd0, fault_code}, 32'h2);
    check("oor_valid", {31'd0, if_valid}, 32'h0);
    check("oor_instr", if_instr, 32'h0000_0013);
    check("oor_addr",  imem_addr, 32'h0040_0080);
    check("oor_pc",    if_pc, 32'h0040_007C);

    // HALT ignores redirect and stall
    redirect = 1'b1; redirect_pc = 32'h0040_0000; stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("halt_addr",  imem_addr, 32'h0040_0080);
      check("halt_valid", {31'd0, if_valid}, 32'h0);
      check("halt_fault", {31'd0, fault}, 32'h1);
      check("halt_code",  {30'd0, fault_code}, 32'h2);
    end

    // Reset from HALT
    redirect = 1'b0; stall = 1'b0; reset = 1'b1;
    step();
    check("rh_fault", {31'd0, fault}, 32'h0);
    check("rh_code",  {30'd0, fault_code}, 32'h0);
    check("rh_addr",  imem_addr, 32'h0040_0000);
    check("rh_valid", {31'd0, if_valid}, 32'h0);
    check("rh_pc",    if_pc, 32'h0);
    reset = 1'b0;
    step();
    check("rh_start_valid", {31'd0, if_valid}, 32'h0);
    step();
    check("rh_run_valid", {31'd0, if_valid}, 32'h1);
    check("rh_run_pc",    if_pc, 32'h0040_0000);
    check("rh_run_addr",  imem_addr, 32'h0040_0004);

    // Misaligned redirect
    redirect = 1'b1; redirect_pc = 32'h0040_0042;
    step();
    check("mis_fault", {31'd0, fault}, 32'h1);
    check("mis_code",  {30'd0, fault_code}, 32'h1);
    check("mis_valid", {31'd0, if_valid}, 32'h0);
    check("mis_instr", if_instr, 32'h0000_0013);
    check("mis_addr",  imem_addr, 32'h0040_0004);
    redirect_pc = 32'h0040_0040; stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("mis_hold_addr",  imem_addr, 32'h0040_0004);
      check("mis_hold_code",  {30'd0, fault_code}, 32'h1);
      check("mis_hold_valid", {31'd0, if_valid}, 32'h0);
    end

    // Redirect below the text base is accepted, then faults on range
    redirect = 1'b0; stall = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    redirect = 1'b1; redirect_pc = 32'h003F_FFFC;
    step();
    check("low_bubble", {31'd0, if_valid}, 32'h0);
    check("low_addr",   imem_addr, 32'h003F_FFFC);
    check("low_nofault", {31'd0, fault}, 32'h0);
    redirect = 1'b0;
    step();
    check("low_fault", {31'd0, fault}, 32'h1);
    check("low_code",  {30'd0, fault_code}, 32'h2);
    check("low_valid", {31'd0, if_valid}, 32'h0);
    check("low_addr2", imem_addr, 32'h003F_FFFC);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
